texture_loader: RTL and testbench
=================================

Name: texture_loader

Overview:
- Sequencer that fills the wall-texture memory from external SPI flash at start-up or on request, replacing the sim-side population of texture data.
- Issues one SPI READ (0x03) command, then streams one byte per texel. Each texel becomes a single-cycle write into the texture memory's write port.
- Writes occur only while the renderer grants access (`allow`, normally blanking), so loading never collides with pixel lookups.

Parameters:
- CHANNEL_BITS, 2, bits per colour channel; texel width is CHANNEL_BITS*3 (≤8).
- TEXEL_COUNT, 8192, number of texels to load (2 sides × 64 cols × 64 rows); benches may reduce it.
- FLASH_ADDR, 24'h000000, flash byte address of texel 0.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load when idle
- allow  in  1  high = texture memory may be written; low = renderer owns it
- spi_miso  in  1  flash serial data out
- spi_cs_n  out  1  flash chip select, active low
- spi_sclk  out  1  SPI clock, mode 0
- spi_mosi  out  1  SPI data to flash
- tex_we  out  1  texture memory write strobe
- tex_addr  out  13  texel address {side,col[5:0],row[5:0]}
- tex_data  out  CHANNEL_BITS*3  texel value
- busy  out  1  high from accepted start until DONE
- done  out  1  one-cycle pulse when load completes

Behaviour:
- Reset (async assert, sync release): state IDLE; spi_cs_n=1, spi_sclk=0, spi_mosi=0, tex_we=0, tex_addr=0, tex_data=0, busy=0, done=0. Reset mid-load aborts immediately; no partial write strobe is issued.
- All outputs are registered.
- States: IDLE → SELECT → CMD → DATA → WRITE → (DATA | FINISH) → IDLE.
- IDLE: start=1 → SELECT; busy=1 the next cycle. start is ignored while busy=1.
- SELECT: one cycle with spi_cs_n=0, spi_sclk=0, mosi = bit 31 of the command word.
- CMD: shifts the 32-bit word {8'h03, FLASH_ADDR} MSB-first.
  - Each bit takes 2 clk: sclk-low cycle (mosi valid), then sclk-high cycle.
  - mosi changes only when sclk returns low.
  - 64 clk total, then → DATA.
- DATA: 8 bits MSB-first, 2 clk each. spi_miso is sampled on the clk edge that ends each sclk-high phase. mosi=0.
- After the 8th sample → WRITE.
- WRITE: one cycle with tex_we=1, tex_data = byte[CHANNEL_BITS*3-1:0] (upper bits discarded), tex_addr = current texel index.
  - If index = TEXEL_COUNT-1 → FINISH.
  - Otherwise increment index → DATA.
- Throttle: DATA holds (sclk=0, cs stays low, no bits shifted) at byte boundaries while allow=0.
  - allow is checked only at the start of each byte; a byte already in flight completes.
  - WRITE is the only state that writes. If allow=0 on entry to WRITE, the write waits with tex_we=0 and fires on the first cycle allow=1; data is held meanwhile.
- Cycle count with allow=1 throughout: 1 + 64 + TEXEL_COUNT×17 + 1 cycles from start to done.
- FINISH: spi_cs_n=1, done=1 for one cycle, busy=0 in that same cycle, then IDLE.
- tex_addr wraps to 0 only via reset or a new start. Each start reloads from FLASH_ADDR with index 0.
- start and reset_n asserted together: reset wins.

Test Plan:
- Reset: hold reset_n=0 with random inputs → all outputs at reset values; spi_cs_n=1 asynchronously, within the same cycle.
- Command: FLASH_ADDR=24'h012345, start pulse → mosi sequence 0x03,0x01,0x23,0x45, MSB-first, sampled at sclk rising edges; cs_n low 1 cycle before the first sclk edge.
- Data: TEXEL_COUNT=4; flash model returns 0xC1,0x02,0x3F,0x80 → writes (addr,data) = (0,0x01),(1,0x02),(2,0x3F),(3,0x00); exactly 4 tex_we pulses; done at cycle 1+64+68+1 after start; busy low thereafter.
- Throttle: drop allow to 0 mid-byte of texel 1 for 40 cycles → that byte completes, its write is deferred until allow=1, sclk is stalled low, no write occurs while allow=0, and final memory contents are unchanged.
- Re-trigger: start pulses while busy are ignored (single command issued); a second start after done reloads addresses 0..3 again.
- Reset mid-load: assert reset_n=0 during texel 2 → cs_n=1 immediately; after release, busy=0 and tex_we stays 0 until a new start.

Source files
------------

// File: rtl/texture_loader.sv
// texture_loader: fills the wall-texture memory from SPI flash (READ 0x03).
// Ports: clk, reset_n, start, allow, spi_* flash pins, tex_* write port,
//        busy (load in progress), done (one-cycle completion pulse).
module texture_loader #(
    parameter int          CHANNEL_BITS = 2,
    parameter int          TEXEL_COUNT  = 8192,
    parameter logic [23:0] FLASH_ADDR   = 24'h000000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      allow,
    input  logic                      spi_miso,
    output logic                      spi_cs_n,
    output logic                      spi_sclk,
    output logic                      spi_mosi,
    output logic                      tex_we,
    output logic [12:0]               tex_addr,
    output logic [CHANNEL_BITS*3-1:0] tex_data,
    output logic                      busy,
    output logic                      done
);

    localparam int          TW       = CHANNEL_BITS * 3;
    localparam logic [31:0] CMD_WORD = {8'h03, FLASH_ADDR};
    localparam logic [12:0] LAST     = 13'(TEXEL_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE, SELECT, CMD, DATA, WRITE, FINISH
    } state_t;

    state_t      state, state_n;
    // cnt: half-bit phase counter; bit 0 is the sclk level of the phase
    logic [5:0]  cnt, cnt_n;
    logic [7:0]  rx, rx_n;

    logic          cs_n_d;
    logic          sclk_d;
    logic          mosi_d;
    logic          we_d;
    logic [12:0]   addr_d;
    logic [TW-1:0] data_d;
    logic          busy_d;
    logic          done_d;

    // state register and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rx       <= '0;
            spi_cs_n <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            tex_we   <= 1'b0;
            tex_addr <= '0;
            tex_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rx       <= rx_n;
            spi_cs_n <= cs_n_d;
            spi_sclk <= sclk_d;
            spi_mosi <= mosi_d;
            tex_we   <= we_d;
            tex_addr <= addr_d;
            tex_data <= data_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // next-state logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rx_n    = rx;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SELECT;
                    cnt_n   = '0;
                end
            end
            SELECT: begin
                state_n = CMD;
                cnt_n   = '0;
            end
            CMD: begin
                if (cnt == 6'd63) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 6'd1;
                end
            end
            DATA: begin
                // a new byte only begins while the renderer grants access
                if (cnt != 6'd0 || allow) begin
                    // miso sampled on the edge that ends each sclk-high phase
                    if (cnt[0]) begin
                        rx_n[~cnt[3:1]] = spi_miso;
                    end
                    if (cnt == 6'd15) begin
                        state_n = WRITE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 6'd1;
                    end
                end
            end
            WRITE: begin
                // tex_we high means the write fires in this cycle
                if (tex_we) begin
                    if (tex_addr == LAST) begin
                        state_n = FINISH;
                    end else begin
                        state_n = DATA;
                        cnt_n   = '0;
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // output logic: values for the next cycle, registered above
    always_comb begin
        cs_n_d = (state_n == IDLE) || (state_n == FINISH);
        sclk_d = ((state_n == CMD) || (state_n == DATA)) && cnt_n[0];
        mosi_d = 1'b0;
        if (state_n == SELECT) begin
            mosi_d = CMD_WORD[31];
        end else if (state_n == CMD) begin
            // bit 31-k for bit number k
            mosi_d = CMD_WORD[~cnt_n[5:1]];
        end
        // a deferred write stays in WRITE until allow is seen high
        we_d   = (state_n == WRITE) && allow;
        busy_d = (state_n == SELECT) || (state_n == CMD) ||
                 (state_n == DATA) || (state_n == WRITE);
        done_d = (state_n == FINISH);
        data_d = tex_data;
        if (state == DATA && state_n == WRITE) begin
            data_d = rx_n[TW-1:0];
        end
        addr_d = tex_addr;
        if (state == IDLE && start) begin
            addr_d = '0;
        end else if (state == WRITE && state_n == DATA) begin
            addr_d = tex_addr + 13'd1;
        end
    end

endmodule

// File: tb/tb_texture_loader.sv
// tb_texture_loader: directed, table-driven bench for texture_loader
// with a behavioural SPI flash model and a write-port monitor.
module tb_texture_loader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       allow = 1'b1;
    logic       miso = 1'b0;
    logic       spi_cs_n, spi_sclk, spi_mosi;
    logic       tex_we;
    logic [12:0] tex_addr;
    logic [5:0] tex_data;
    logic       busy, done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  flash;
        logic [12:0] addr;
        logic [5:0]  data;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    texture_loader #(
        .CHANNEL_BITS(2),
        .TEXEL_COUNT(4),
        .FLASH_ADDR(24'h012345)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .allow(allow),
        .spi_miso(miso),
        .spi_cs_n(spi_cs_n),
        .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi),
        .tex_we(tex_we),
        .tex_addr(tex_addr),
        .tex_data(tex_data),
        .busy(busy),
        .done(done)
    );

    // flash model: mode 0, captures command on rising sclk, shifts data on falling
    logic [31:0] cmd_sr = '0;
    int cmd_count = 0;
    int ncmd = 0;
    int kbit = 0;
    logic sclk_prev = 1'b0;
    always @(spi_sclk or spi_cs_n) begin
        if (spi_cs_n) begin
            ncmd = 0;
            kbit = 0;
            miso = 1'b0;
        end else if (spi_sclk && !sclk_prev) begin
            if (ncmd < 32) begin
                cmd_sr = {cmd_sr[30:0], spi_mosi};
                if (ncmd == 31) cmd_count++;
            end
            ncmd++;
        end else if (!spi_sclk && sclk_prev && ncmd >= 32) begin
            if (kbit < 32) miso = vecs[kbit / 8].flash[7 - (kbit % 8)];
            else miso = 1'b0;
            kbit++;
        end
        sclk_prev = spi_sclk;
    end

    // write-port monitor
    logic [12:0] wa[64];
    logic [5:0]  wd[64];
    int wr_count = 0;
    int viol = 0;
    always @(negedge clk) begin
        if (tex_we) begin
            if (wr_count < 64) begin
                wa[wr_count] = tex_addr;
                wd[wr_count] = tex_data;
            end
            wr_count++;
            if (!allow) viol++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 2000) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic check_writes(input string tag, input int base);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_addr"}, 32'(wa[base + i]), 32'(vecs[i].addr));
            chk({tag, "_data"}, 32'(wd[base + i]), 32'(vecs[i].data));
        end
    endtask

    initial begin
        int n, base, sclk_hi, wr_win, act;
        vecs[0] = '{8'hC1, 13'd0, 6'h01};
        vecs[1] = '{8'h02, 13'd1, 6'h02};
        vecs[2] = '{8'h3F, 13'd2, 6'h3F};
        vecs[3] = '{8'h80, 13'd3, 6'h00};

        // reset with random inputs
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom_range(0, 1));
            allow = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_we", 32'(tex_we), 32'd0);
        chk("rst_addr", 32'(tex_addr), 32'd0);
        chk("rst_data", 32'(tex_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        start = 1'b0;
        allow = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // load 1: full timing, extra starts while busy are ignored
        base = wr_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        chk("sel_cs_n", 32'(spi_cs_n), 32'd0);
        chk("sel_sclk", 32'(spi_sclk), 32'd0);
        chk("sel_mosi", 32'(spi_mosi), 32'd0);
        chk("sel_busy", 32'(busy), 32'd1);
        while (!done && n < 1000) begin
            start = (n == 10 || n == 100);
            tick();
            n++;
        end
        start = 1'b0;
        chk("done_cycle", 32'(n), 32'd134);
        chk("fin_busy", 32'(busy), 32'd0);
        chk("fin_cs_n", 32'(spi_cs_n), 32'd1);
        chk("cmd_word", cmd_sr, 32'h03012345);
        chk("cmd_count1", 32'(cmd_count), 32'd1);
        tick();
        chk("done_pulse", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        chk("last_addr", 32'(tex_addr), 32'd3);
        chk("wr_count1", 32'(wr_count - base), 32'd4);
        check_writes("load1", base);
        chk("viol1", 32'(viol), 32'd0);

        // load 2: throttle mid-byte of texel 1
        base = wr_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (wr_count - base < 1 && n < 1000) begin
            tick();
            n++;
        end
        chk("first_write", 32'(wr_count - base), 32'd1);
        repeat (5) tick();
        allow = 1'b0;
        sclk_hi = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k >= 20 && spi_sclk) sclk_hi++;
        end
        wr_win = wr_count - base;
        chk("stall_sclk", 32'(sclk_hi), 32'd0);
        chk("defer_write", 32'(wr_win), 32'd1);
        chk("stall_cs_n", 32'(spi_cs_n), 32'd0);
        allow = 1'b1;
        tick();
        tick();
        chk("release_write", 32'(wr_count - base), 32'd2);
        wait_done(n);
        tick();
        chk("wr_count2", 32'(wr_count - base), 32'd4);
        check_writes("load2", base);
        chk("viol2", 32'(viol), 32'd0);
        chk("cmd_count2", 32'(cmd_count), 32'd2);

        // load 3: reset during texel 2
        base = wr_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (wr_count - base < 2 && n < 1000) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("pre_rst_cs_n", 32'(spi_cs_n), 32'd0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_cs_n", 32'(spi_cs_n), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_addr", 32'(tex_addr), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        act = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (busy || tex_we || !spi_cs_n) act++;
        end
        chk("after_rst_quiet", 32'(act), 32'd0);
        chk("rst_load_writes", 32'(wr_count - base), 32'd2);

        // load 4: new start after reset loads normally
        base = wr_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        tick();
        chk("wr_count4", 32'(wr_count - base), 32'd4);
        check_writes("load4", base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
